// File: rtl/cc_pkg.sv
// Shared types and constants for the cache-line serializer slice.
// Contents:
//   CC_BEAT_W / CC_BEATS / CC_OFFSET_W / CC_LINE_W : line geometry
//   cc_line_req_t                                  : buffered {offset, data} record
//   cc_beat_idx()                                  : wrap-ordered beat index
package cc_pkg;

  localparam int CC_BEAT_W   = 64;
  localparam int CC_BEATS    = 8;
  localparam int CC_OFFSET_W = 3;
  localparam int CC_LINE_W   = CC_BEAT_W * CC_BEATS;

  typedef struct packed {
    logic [CC_OFFSET_W-1:0] offset;
    logic [CC_LINE_W-1:0]   data;
  } cc_line_req_t;

  // Addition is truncated to the offset width, so the index wraps mod CC_BEATS
  // and matches the fill unit's critical-word-first order.
  function automatic logic [CC_OFFSET_W-1:0] cc_beat_idx(
    input logic [CC_OFFSET_W-1:0] offset,
    input logic [CC_OFFSET_W-1:0] beat
  );
    return offset + beat;
  endfunction

endpackage

// File: rtl/cc_line_fifo.sv
// DEPTH-entry synchronous FIFO of cc_line_req_t records. Generic enough to be
// reused on the miss-address path.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset (pointers and count only)
//   push/wdata : write one record at the tail (ignored when full)
//   pop        : drop the head record (ignored when empty)
//   rdata      : current head record (combinational read of the storage)
//   full/empty : occupancy flags, registered-state derived
//   count      : number of records held, 0..DEPTH
module cc_line_fifo
  import cc_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  cc_line_req_t     wdata,
  input  logic             pop,
  output cc_line_req_t     rdata,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  cc_line_req_t     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  // Storage is deliberately not reset; entries are only visible once counted.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // DEPTH is a power of two, so natural pointer overflow implements the wrap.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/cc_line_serializer.sv
// Buffers whole cache lines and replays each as a BEATS-beat wrap-ordered
// burst on an AXI-R-style valid/ready channel.
// Ports:
//   clk, rst_n                 : clock, synchronous active-low reset
//   line_valid_i/line_ready_o  : upstream line handshake (ready = buffer not full)
//   line_data_i, line_offset_i : line payload and critical-word beat index
//   rdata_o/rlast_o/rvalid_o   : downstream beat, last-beat flag, valid
//   rready_i                   : downstream accepts the beat
//
// state | meaning
// ------+---------------------------------------------------------
// IDLE  | no line buffered; channel quiet, rdata_o forced to zero
// SEND  | head line being emitted, beat cnt selects the data slice
module cc_line_serializer
  import cc_pkg::*;
#(
  parameter  int BEAT_W = CC_BEAT_W,
  parameter  int BEATS  = CC_BEATS,
  parameter  int DEPTH  = 2,
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    line_valid_i,
  output logic                    line_ready_o,
  input  logic [BEAT_W*BEATS-1:0] line_data_i,
  input  logic [CC_OFFSET_W-1:0]  line_offset_i,
  output logic [BEAT_W-1:0]       rdata_o,
  output logic                    rlast_o,
  output logic                    rvalid_o,
  input  logic                    rready_i
);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  localparam logic [CC_OFFSET_W-1:0] LAST_BEAT = CC_OFFSET_W'(BEATS - 1);

  state_t                 state_q, state_d;
  logic [CC_OFFSET_W-1:0] cnt_q, cnt_d;
  logic [CC_OFFSET_W-1:0] idx;
  cc_line_req_t           wr_req;
  cc_line_req_t           head;
  logic                   push;
  logic                   pop;
  logic                   full;
  logic                   empty;
  logic [CNT_W-1:0]       count;

  assign wr_req.offset = line_offset_i;
  assign wr_req.data   = line_data_i;

  // Ready comes straight from the registered occupancy; a pop in the same
  // cycle does not open the buffer early, keeping rready_i off this path.
  assign line_ready_o = ~full;
  assign push         = line_valid_i & ~full;
  assign idx          = cc_beat_idx(head.offset, cnt_q);

  cc_line_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (wr_req),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pop      = 1'b0;
    rvalid_o = 1'b0;
    rlast_o  = 1'b0;
    rdata_o  = '0;
    case (state_q)
      IDLE: begin
        if (push) state_d = SEND;
      end
      SEND: begin
        rvalid_o = 1'b1;
        rlast_o  = (cnt_q == LAST_BEAT);
        rdata_o  = head.data[BEAT_W*int'(idx) +: BEAT_W];
        if (rready_i) begin
          if (cnt_q == LAST_BEAT) begin
            cnt_d = '0;
            pop   = 1'b1;
            // Stay in SEND when another line is queued or arriving now, so the
            // next line's first beat follows with no bubble.
            if (count == CNT_W'(1) && !push) state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State mirrors buffer occupancy; the flag is kept to tie the two together.
  logic unused_empty;
  assign unused_empty = empty;

endmodule

// File: tb/tb_cc_line_serializer.sv
module tb_cc_line_serializer;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         line_valid_i;
  logic         line_ready_o;
  logic [511:0] line_data_i;
  logic [2:0]   line_offset_i;
  logic [63:0]  rdata_o;
  logic         rlast_o;
  logic         rvalid_o;
  logic         rready_i;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cc_line_serializer #(.BEAT_W(64), .BEATS(8), .DEPTH(2)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .line_valid_i  (line_valid_i),
    .line_ready_o  (line_ready_o),
    .line_data_i   (line_data_i),
    .line_offset_i (line_offset_i),
    .rdata_o       (rdata_o),
    .rlast_o       (rlast_o),
    .rvalid_o      (rvalid_o),
    .rready_i      (rready_i)
  );

  typedef struct {
    logic [15:0] tag;
    logic [2:0]  off;
    int          stall_beat;
    int          stall_len;
    int          order[8];
    int          cycles;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] mk_beat(input logic [15:0] tag, input int k);
    logic [2:0] k3;
    k3 = 3'(k);
    return {tag, 32'h0, 13'h0, k3};
  endfunction

  function automatic logic [511:0] mk_line(input logic [15:0] tag);
    logic [511:0] l;
    for (int k = 0; k < 8; k++) l[64*k +: 64] = mk_beat(tag, k);
    return l;
  endfunction

  task automatic check_idle(input string name);
    check({name, "_rvalid"}, 64'(rvalid_o), 64'd0);
    check({name, "_rlast"},  64'(rlast_o),  64'd0);
    check({name, "_rdata"},  rdata_o,       64'd0);
    check({name, "_ready"},  64'(line_ready_o), 64'd1);
  endtask

  // Called at a negedge: pushes one line, then drains it with an optional stall.
  task automatic run_line(input vec_t v, input string name);
    int b, cyc, st;
    line_valid_i  = 1'b1;
    line_data_i   = mk_line(v.tag);
    line_offset_i = v.off;
    rready_i      = 1'b1;
    b = 0; cyc = 0; st = 0;
    while (b < 8 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      line_valid_i = 1'b0;
      if (b == v.stall_beat && st < v.stall_len) begin
        rready_i = 1'b0;
        st++;
      end else begin
        rready_i = 1'b1;
      end
      check({name, "_rvalid"}, 64'(rvalid_o), 64'd1);
      check({name, "_rdata"},  rdata_o, mk_beat(v.tag, v.order[b]));
      check({name, "_rlast"},  64'(rlast_o), 64'(b == 7));
      if (rready_i) b++;
    end
    check({name, "_cycles"}, 64'(cyc), 64'(v.cycles));
    @(negedge clk);
    check({name, "_end_rvalid"}, 64'(rvalid_o), 64'd0);
  endtask

  int offs[3];
  logic [15:0] tags[3];

  initial begin
    vecs[0] = '{tag:16'h1111, off:3'd0, stall_beat:-1, stall_len:0,
                order:'{0,1,2,3,4,5,6,7}, cycles:8};
    vecs[1] = '{tag:16'h1111, off:3'd5, stall_beat:-1, stall_len:0,
                order:'{5,6,7,0,1,2,3,4}, cycles:8};
    vecs[2] = '{tag:16'h2222, off:3'd0, stall_beat:2,  stall_len:3,
                order:'{0,1,2,3,4,5,6,7}, cycles:11};
    vecs[3] = '{tag:16'h3333, off:3'd3, stall_beat:7,  stall_len:2,
                order:'{3,4,5,6,7,0,1,2}, cycles:10};

    rst_n = 1'b0; line_valid_i = 1'b0; line_data_i = '0;
    line_offset_i = '0; rready_i = 1'b0;
    repeat (2) @(negedge clk);
    check_idle("rst");
    rst_n = 1'b1;
    @(negedge clk);
    check_idle("post_rst");

    for (int i = 0; i < 4; i++) run_line(vecs[i], $sformatf("vec%0d", i));

    // Full buffer and back-to-back bursts: A(off 0), B(off 2), C(off 7).
    tags = '{16'hAAAA, 16'hBBBB, 16'hCCCC};
    offs = '{0, 2, 7};
    rready_i = 1'b0;
    line_valid_i = 1'b1; line_data_i = mk_line(tags[0]); line_offset_i = 3'(offs[0]);
    @(negedge clk);
    check("full_rdy_a", 64'(line_ready_o), 64'd1);
    line_data_i = mk_line(tags[1]); line_offset_i = 3'(offs[1]);
    @(negedge clk);
    check("full_rdy_b", 64'(line_ready_o), 64'd0);
    line_data_i = mk_line(tags[2]); line_offset_i = 3'(offs[2]);
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      check("stall_ready",  64'(line_ready_o), 64'd0);
      check("stall_rvalid", 64'(rvalid_o), 64'd1);
      check("stall_rdata",  rdata_o, mk_beat(tags[0], offs[0]));
    end
    rready_i = 1'b1;
    for (int i = 0; i < 24; i++) begin
      if (i > 0) @(negedge clk);
      if (i == 9) line_valid_i = 1'b0;
      check("b2b_rvalid", 64'(rvalid_o), 64'd1);
      check("b2b_rdata",  rdata_o, mk_beat(tags[i/8], (offs[i/8] + i%8) % 8));
      check("b2b_rlast",  64'(rlast_o), 64'(i % 8 == 7));
      check("b2b_ready",  64'(line_ready_o), 64'((i == 8) || (i >= 16)));
    end
    @(negedge clk);
    check("b2b_end_rvalid", 64'(rvalid_o), 64'd0);

    // Reset in the middle of line A with line B queued.
    line_valid_i = 1'b1; line_data_i = mk_line(16'h4444); line_offset_i = 3'd0;
    rready_i = 1'b1;
    @(negedge clk);
    line_data_i = mk_line(16'h5555); line_offset_i = 3'd1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      line_valid_i = 1'b0;
    end
    check("mid_beat4", rdata_o, mk_beat(16'h4444, 4));
    rst_n = 1'b0;
    @(negedge clk);
    check_idle("mid_rst");
    rst_n = 1'b1;
    @(negedge clk);
    check_idle("mid_post");
    run_line(vecs[0], "after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

endmodule

// File: doc/cc_line_serializer.md
Name: cc_line_serializer

Overview:
Transmit-side counterpart of the cache fill path. Accepts whole 512-bit cache lines with a critical-word offset, buffers up to DEPTH lines, and emits each as an 8-beat, 64-bit, wrap-ordered burst on an AXI-R-style valid/ready channel, with last asserted on beat 7. It sits between the SRAM read port (hit data) and the CPU-facing R channel. Beat order matches the fill unit: (offset + beat) mod 8.

Parameters:
BEAT_W, 64, width of one data beat
BEATS, 8, beats per line (power of two); line width = BEAT_W*BEATS
DEPTH, 2, line-buffer entries (power of two, >=2)

Ports:
clk  input  1  clock
rst_n  input  1  synchronous active-low reset
line_valid_i  input  1  upstream line request valid
line_ready_o  output  1  buffer can accept a line
line_data_i  input  512  cache line; beat k occupies bits [64k+63:64k]
line_offset_i  input  3  critical-word beat index (addr[5:3])
rdata_o  output  64  beat data
rlast_o  output  1  final beat of the current line
rvalid_o  output  1  beat valid
rready_i  input  1  downstream accepts beat

Behaviour:
- Reset (rst_n=0 at posedge): buffer count=0, wr/rd pointers=0, beat counter cnt=0. Outputs after reset: rvalid_o=0, rlast_o=0, rdata_o=0, line_ready_o=1.
- Push: line_valid_i & line_ready_o at posedge writes {offset, data} to the tail. line_ready_o = (count < DEPTH), driven from registers only; it does not depend on a same-cycle pop.
- States: IDLE (count==0) and SEND (count>0). In IDLE, rvalid_o=0 and rdata_o=0. IDLE->SEND the cycle after a push, so the minimum latency from push to first beat is 1 cycle. SEND->IDLE after the last-beat handshake when no other line is buffered.
- In SEND: rvalid_o=1, idx = (head.offset + cnt) mod 8 using 3-bit wraparound, rdata_o = head.data[64*idx +: 64], rlast_o = (cnt==7).
- Beat handshake = rvalid_o & rready_i. If cnt<7, cnt+1. If cnt==7, cnt=0, the head is popped and count decrements.
- Back-to-back: if another line is buffered at the pop, rvalid_o stays 1 the next cycle with the new head's first beat. There are no bubbles, giving a sustained 1 beat/cycle.
- Stability: while rvalid_o=1 and rready_i=0, rdata_o, rlast_o and rvalid_o hold unchanged. rvalid_o never deasserts without a handshake.
- Simultaneous push and pop in one cycle: count is unchanged and both pointers advance. A push when full cannot happen because ready is low; line_valid_i is ignored in that case.
- Pointers wrap modulo DEPTH. count ranges 0..DEPTH.
- Offset 0 gives beat order 0..7. Offset 5 gives 5,6,7,0,1,2,3,4.
- Reset mid-burst: the burst is abandoned and all buffered lines are discarded. rvalid_o=0 from the first cycle after the reset edge.
- No combinational path from rready_i to line_ready_o or rvalid_o.

Decomposition:
- Package cc_pkg holds:
  - constants CC_BEAT_W=64, CC_BEATS=8, CC_OFFSET_W=3, CC_LINE_W=512;
  - typedef cc_line_req_t = struct packed {logic [2:0] offset; logic [511:0] data;}.
- Sub-module cc_line_fifo is a DEPTH-entry synchronous FIFO of cc_line_req_t with full, empty, push and pop, reusable for the miss-address path.
- The top holds cnt, the idx mux and the output logic.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles, then 1 -> rvalid_o=0, rdata_o=0, rlast_o=0, line_ready_o=1.
- Single line: push beat k = 64'h1111_0000_0000_000k with offset=0 and rready_i=1 -> beats k=0..7 on consecutive cycles starting 1 cycle after the push; rlast_o only on k=7.
- Wrap order: same line with offset=5 -> rdata_o sequence k=5,6,7,0,1,2,3,4; rlast_o on the 8th beat (k=4).
- Backpressure: hold rready_i=0 for 3 cycles at beat 2 -> rdata_o/rvalid_o stable across those cycles; the total burst takes 11 cycles, with no lost or duplicated beats.
- Full and back-to-back: push lines A, B, then C while rready_i=0 -> line_ready_o=0 after B and C stalls. Release rready_i -> 16 contiguous beats A then B with no gap, ready returns to 1 after A's last beat, and C follows.
- Reset mid-burst: assert rst_n=0 at beat 4 of line A with line B buffered -> next cycle rvalid_o=0 and line_ready_o=1; a new push emits from beat 0 cleanly.
